// File: rtl/scratch_responder_if.sv
// CPU transaction interface between an initiator (master) and a responder (slave).
interface scratch_responder_if;
   logic [31:0] address;
   logic [31:0] data_out;
   logic [31:0] data_in;
   logic        write_enable;
   logic [3:0]  write_mask;
   logic        transaction_begin;
   logic        transaction_end;
   logic        error;

   modport master (
      output address, data_out, write_enable, write_mask, transaction_begin,
      input  data_in, transaction_end, error
   );

   modport slave (
      input  address, data_out, write_enable, write_mask, transaction_begin,
      output data_in, transaction_end, error
   );
endinterface

// File: rtl/scratch_responder.sv
// Scratch RAM responder with programmable wait states on the CPU transaction interface.
// Optional macro SCRATCH_OOR_TRAP_EN: out-of-range accesses raise error and reads return 32'hDEAD_BEEF.
module scratch_responder #(
   parameter int          DEPTH       = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
   parameter int          WAIT_STATES = 0
) (
   input  logic               clk,
   input  logic               reset,
   scratch_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

`ifdef SCRATCH_OOR_TRAP_EN
   localparam logic [31:0] MISS_DATA = 32'hDEAD_BEEF;
   localparam logic        MISS_TRAP = 1'b1;
`else
   localparam logic [31:0] MISS_DATA = 32'h0000_0000;
   localparam logic        MISS_TRAP = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  mask);
      logic [31:0] merged;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      end
      return merged;
   endfunction

   state_t         r_state;
   logic [3:0]     r_cnt;
   logic [AW-1:0]  r_idx;
   logic [31:0]    r_wdata;
   logic           r_we;
   logic [3:0]     r_mask;
   logic           r_hit;
   logic [31:0]    r_data_in;
   logic           r_end;
   logic           r_error;
   logic [31:0]    r_mem [DEPTH];

   logic           w_hit;
   logic [AW-1:0]  w_idx;
   logic           w_access;
   logic           w_mem_we;
   logic [31:0]    w_rd_word;
   logic [31:0]    w_wr_word;
   logic           w_unused;

   assign w_hit     = (bus.address[31:AW+2] == BASE_ADDR[31:AW+2]);
   assign w_idx     = bus.address[AW+1:2];
   assign w_access  = (r_state == S_WAIT) && (r_cnt == 4'd0);
   assign w_mem_we  = w_access && r_we && r_hit;
   assign w_rd_word = r_mem[r_idx];
   assign w_wr_word = merge_bytes(w_rd_word, r_wdata, r_mask);
   assign w_unused  = ^bus.address[1:0];

   assign bus.data_in         = r_data_in;
   assign bus.transaction_end = r_end;
   assign bus.error           = r_error;

   // Storage: byte-masked write on the completion edge; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[r_idx] <= w_wr_word;
      end
   end

   // Request FSM: accept once, count wait states, complete, then hold until begin drops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= 4'd0;
         r_idx     <= '0;
         r_wdata   <= 32'h0000_0000;
         r_we      <= 1'b0;
         r_mask    <= 4'b0000;
         r_hit     <= 1'b0;
         r_data_in <= 32'h0000_0000;
         r_end     <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_end   <= 1'b0;
               r_error <= 1'b0;
               if (bus.transaction_begin) begin
                  r_idx   <= w_idx;
                  r_wdata <= bus.data_out;
                  r_we    <= bus.write_enable;
                  r_mask  <= bus.write_mask;
                  r_hit   <= w_hit;
                  r_cnt   <= 4'(WAIT_STATES);
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_end   <= 1'b1;
                  r_error <= MISS_TRAP & ~r_hit;
                  if (!r_we) begin
                     r_data_in <= r_hit ? w_rd_word : MISS_DATA;
                  end
                  r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               r_end   <= 1'b0;
               r_error <= 1'b0;
               if (!bus.transaction_begin) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_end   <= 1'b0;
               r_error <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_scratch_responder.sv
// Scoreboard bench for scratch_responder at WAIT_STATES 0, 3 and 5.
module tb_scratch_responder;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

`ifdef SCRATCH_OOR_TRAP_EN
   localparam logic [31:0] MISS_RD  = 32'hDEAD_BEEF;
   localparam logic        MISS_ERR = 1'b1;
`else
   localparam logic [31:0] MISS_RD  = 32'h0000_0000;
   localparam logic        MISS_ERR = 1'b0;
`endif

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_rd [3];

   logic [31:0] drv_addr = 32'h0;
   logic [31:0] drv_data = 32'h0;
   logic        drv_we   = 1'b0;
   logic [3:0]  drv_mask = 4'h0;
   logic        drv_beg  = 1'b0;
   int          sel      = 0;

   scratch_responder_if if0 ();
   scratch_responder_if if3 ();
   scratch_responder_if if5 ();

   assign if0.address = drv_addr;  assign if3.address = drv_addr;  assign if5.address = drv_addr;
   assign if0.data_out = drv_data; assign if3.data_out = drv_data; assign if5.data_out = drv_data;
   assign if0.write_enable = drv_we; assign if3.write_enable = drv_we; assign if5.write_enable = drv_we;
   assign if0.write_mask = drv_mask; assign if3.write_mask = drv_mask; assign if5.write_mask = drv_mask;
   assign if0.transaction_begin = drv_beg && (sel == 0);
   assign if3.transaction_begin = drv_beg && (sel == 1);
   assign if5.transaction_begin = drv_beg && (sel == 2);

   scratch_responder #(.WAIT_STATES(0)) u_ws0 (.clk(clk), .reset(reset), .bus(if0));
   scratch_responder #(.WAIT_STATES(3)) u_ws3 (.clk(clk), .reset(reset), .bus(if3));
   scratch_responder #(.WAIT_STATES(5)) u_ws5 (.clk(clk), .reset(reset), .bus(if5));

   logic        w_end, w_err, w_stray;
   logic [31:0] w_data;
   assign w_end  = (sel == 0) ? if0.transaction_end : (sel == 1) ? if3.transaction_end : if5.transaction_end;
   assign w_err  = (sel == 0) ? if0.error : (sel == 1) ? if3.error : if5.error;
   assign w_data = (sel == 0) ? if0.data_in : (sel == 1) ? if3.data_in : if5.data_in;
   assign w_stray = ((sel != 0) && if0.transaction_end) || ((sel != 1) && if3.transaction_end) ||
                    ((sel != 2) && if5.transaction_end);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pop one expectation per completion pulse, and police pulse width and strays.
   int   end_run = 0;
   exp_t mon_e;
   always @(negedge clk) begin
      if (reset) begin
         end_run = 0;
      end else begin
         if (w_end) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_end: got end=1 expected no pending request (sel=%0d)", sel);
            end else begin
               mon_e = sb_q.pop_front();
               check("data_in", w_data, mon_e.data);
               check("error", {31'b0, w_err}, {31'b0, mon_e.err});
            end
            end_run++;
         end else if (end_run != 0) begin
            check("end_pulse_len", end_run, 1);
            end_run = 0;
         end
         if (!w_end && w_err) check("error_without_end", {31'b0, w_err}, 32'h0);
         if (w_stray) check("stray_end", {31'b0, w_stray}, 32'h0);
      end
   end

   task automatic txn(input int s, input logic [31:0] a, input logic [31:0] d, input logic we,
                      input logic [3:0] m, input logic [31:0] exp_rd, input bit miss,
                      input int exp_lat, input bit scramble, input int hold_cycles);
      exp_t e;
      int   lat = 0;
      int   extra = 0;
      sel = s; drv_addr = a; drv_data = d; drv_we = we; drv_mask = m;
      if (we) begin
         e.data = last_rd[s];
         e.err  = miss ? MISS_ERR : 1'b0;
      end else begin
         e.data = miss ? MISS_RD : exp_rd;
         e.err  = miss ? MISS_ERR : 1'b0;
         last_rd[s] = e.data;
      end
      sb_q.push_back(e);
      drv_beg = 1'b1;
      do begin
         @(posedge clk); #1; lat++;
         if (scramble && lat == 1) begin
            drv_addr = a ^ 32'h0000_0080; drv_data = ~d; drv_we = ~we; drv_mask = ~m;
         end
      end while (!w_end && lat < 50);
      if (!w_end) begin
         checks++; errors++;
         $display("FAIL end_timeout: got no end after %0d cycles expected %0d", lat, exp_lat);
      end else begin
         check("latency", lat, exp_lat);
      end
      for (int i = 0; i < hold_cycles; i++) begin
         @(posedge clk); #1;
         if (w_end) extra++;
      end
      if (hold_cycles > 0) check("held_begin_no_repeat", extra, 0);
      drv_beg = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 3; i++) last_rd[i] = 32'h0;
      #2 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_data_in", if0.data_in, 32'h0);
      check("rst_end", {31'b0, if3.transaction_end}, 32'h0);
      check("rst_error", {31'b0, if5.error}, 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      // WAIT_STATES = 0
      txn(0, 32'h3000_0010, 32'h1234_5678, 1'b1, 4'b1111, 32'h0, 1'b0, 2, 1'b0, 0);
      txn(0, 32'h3000_0010, 32'h0,         1'b0, 4'b0000, 32'h1234_5678, 1'b0, 2, 1'b0, 0);
      txn(0, 32'h3000_0020, 32'hAABB_CCDD, 1'b1, 4'b1111, 32'h0, 1'b0, 2, 1'b0, 0);
      txn(0, 32'h3000_0020, 32'h1122_3344, 1'b1, 4'b0101, 32'h0, 1'b0, 2, 1'b0, 0);
      txn(0, 32'h3000_0022, 32'h0,         1'b0, 4'b0000, 32'hAA22_CC44, 1'b0, 2, 1'b0, 0);
      txn(0, 32'h3000_0020, 32'hFFFF_FFFF, 1'b1, 4'b0000, 32'h0, 1'b0, 2, 1'b0, 0);
      txn(0, 32'h3000_0020, 32'h0,         1'b0, 4'b0000, 32'hAA22_CC44, 1'b0, 2, 1'b0, 0);
      txn(0, 32'h3000_0400, 32'h0,         1'b0, 4'b0000, 32'h0, 1'b1, 2, 1'b0, 0);
      txn(0, 32'h3000_0410, 32'hCAFE_F00D, 1'b1, 4'b1111, 32'h0, 1'b1, 2, 1'b0, 0);
      txn(0, 32'h3000_0010, 32'h0,         1'b0, 4'b0000, 32'h1234_5678, 1'b0, 2, 1'b0, 0);
      txn(0, 32'h2FFF_FFFC, 32'h0,         1'b0, 4'b0000, 32'h0, 1'b1, 2, 1'b0, 0);
      txn(0, 32'h3000_03FC, 32'hFEED_FACE, 1'b1, 4'b1111, 32'h0, 1'b0, 2, 1'b0, 0);
      txn(0, 32'h3000_03FC, 32'h0,         1'b0, 4'b0000, 32'hFEED_FACE, 1'b0, 2, 1'b0, 0);
      txn(0, 32'h3000_0020, 32'h0,         1'b0, 4'b0000, 32'hAA22_CC44, 1'b0, 2, 1'b0, 20);
      txn(0, 32'h3000_0010, 32'h0,         1'b0, 4'b0000, 32'h1234_5678, 1'b0, 2, 1'b0, 0);

      // WAIT_STATES = 3, inputs disturbed after acceptance
      txn(1, 32'h3000_0000, 32'h55AA_55AA, 1'b1, 4'b1111, 32'h0, 1'b0, 5, 1'b1, 0);
      txn(1, 32'h3000_0000, 32'h0,         1'b0, 4'b0000, 32'h55AA_55AA, 1'b0, 5, 1'b1, 0);
      txn(1, 32'h3000_0000, 32'h0,         1'b0, 4'b0000, 32'h55AA_55AA, 1'b0, 5, 1'b0, 0);

      // WAIT_STATES = 5, reset during wait on a write
      txn(2, 32'h3000_0040, 32'h0F0F_0F0F, 1'b1, 4'b1111, 32'h0, 1'b0, 7, 1'b0, 0);
      txn(2, 32'h3000_0040, 32'h0,         1'b0, 4'b0000, 32'h0F0F_0F0F, 1'b0, 7, 1'b0, 0);
      sel = 2; drv_addr = 32'h3000_0040; drv_data = 32'hFFFF_FFFF; drv_we = 1'b1; drv_mask = 4'b1111;
      drv_beg = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("midrst_data_in", if5.data_in, 32'h0);
      check("midrst_end", {31'b0, if5.transaction_end}, 32'h0);
      check("midrst_error", {31'b0, if5.error}, 32'h0);
      drv_beg = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) last_rd[i] = 32'h0;
      @(posedge clk); #1;
      txn(2, 32'h3000_0040, 32'h0,         1'b0, 4'b0000, 32'h0F0F_0F0F, 1'b0, 7, 1'b0, 0);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
